// File: rtl/sr_trace_pkg.sv
// Shared constants, FSM encoding and byte-order helper for the UART trace transmitter.
// Build option: SR_TRACE_SYNC_EN prefixes every record with a sync byte.
package sr_trace_pkg;

    localparam int REC_W = 96;

`ifdef SR_TRACE_SYNC_EN
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         REC_BYTES = 13;
`else
    localparam int         REC_BYTES = 12;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // Record layout is {reg, instr, pc}, so byte k of the wire order is simply bits [8k+7:8k].
    function automatic logic [7:0] rec_byte(input logic [REC_W-1:0] rec, input logic [3:0] idx);
        logic [REC_W-1:0] w_shifted;
`ifdef SR_TRACE_SYNC_EN
        if (idx == 4'd0) begin
            return SYNC_BYTE;
        end
        w_shifted = rec >> {idx - 4'd1, 3'b000};
`else
        w_shifted = rec >> {idx, 3'b000};
`endif
        return w_shifted[7:0];
    endfunction

endpackage

// File: rtl/sr_trace_fifo.sv
// DEPTH x WIDTH synchronous FIFO with extended pointers; push and pop may coincide even when full.
module sr_trace_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 96
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_count = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/sr_trace_tx.sv
// Captures per-step CPU trace records and streams them as UART 8N1 bytes, pc/instr/a0 LSB-first.
// Build option: SR_TRACE_SYNC_EN adds a leading 8'hA5 sync byte to each record.
module sr_trace_tx #(
    parameter int DEPTH   = 8,
    parameter int CLK_DIV = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trace_valid,
    input  logic [31:0] trace_pc,
    input  logic [31:0] trace_instr,
    input  logic [31:0] trace_reg,
    output logic        tx,
    output logic        busy,
    output logic [7:0]  ovf_cnt
);
    import sr_trace_pkg::*;

    localparam int              AW        = $clog2(DEPTH);
    localparam int              TW        = $clog2(CLK_DIV);
    localparam logic [TW-1:0]   TIMER_TOP = TW'(CLK_DIV - 1);
    localparam logic [3:0]      LAST_BYTE = 4'(REC_BYTES - 1);

    logic             w_full;
    logic             w_empty;
    logic [AW:0]      w_count;
    logic [REC_W-1:0] w_rdata;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic             w_nonempty_next;
    logic             w_idle_next;
    logic             w_timer_done;
    logic [7:0]       w_byte;

    tx_state_e        r_state;
    logic [TW-1:0]    r_timer;
    logic [3:0]       r_byte_idx;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [REC_W-1:0] r_hold;
    logic             r_tx;
    logic             r_busy;
    logic [7:0]       r_ovf;

    sr_trace_fifo #(.DEPTH(DEPTH), .WIDTH(REC_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata ({trace_reg, trace_instr, trace_pc}),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // A full FIFO still accepts a record in the cycle the transmitter drains one.
    assign w_pop           = (r_state == ST_IDLE) && !w_empty;
    assign w_push          = trace_valid && (!w_full || w_pop);
    assign w_drop          = trace_valid && w_full && !w_pop;
    assign w_nonempty_next = w_push || (w_count > {{AW{1'b0}}, w_pop});
    assign w_timer_done    = (r_timer == '0);
    assign w_idle_next     = ((r_state == ST_IDLE) && !w_pop) ||
                             ((r_state == ST_STOP) && w_timer_done && (r_byte_idx == LAST_BYTE));
    assign w_byte          = rec_byte(r_hold, r_byte_idx);

    always_ff @(posedge clk) begin
        if (w_pop) r_hold <= w_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= '0;
        end else if (w_drop && (r_ovf != 8'hFF)) begin
            r_ovf <= r_ovf + 8'd1;
        end
    end

    // The line level is registered from the current state, so tx trails the FSM by one clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_timer    <= '0;
            r_byte_idx <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_busy <= w_nonempty_next || !w_idle_next;
            case (r_state)
                ST_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_state    <= ST_START;
                        r_timer    <= TIMER_TOP;
                        r_byte_idx <= '0;
                    end
                end
                ST_START: begin
                    r_tx <= 1'b0;
                    if (w_timer_done) begin
                        r_state   <= ST_DATA;
                        r_timer   <= TIMER_TOP;
                        r_shift   <= w_byte;
                        r_bit_idx <= '0;
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
                ST_DATA: begin
                    r_tx <= r_shift[0];
                    if (w_timer_done) begin
                        r_timer   <= TIMER_TOP;
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) r_state <= ST_STOP;
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
                ST_STOP: begin
                    r_tx <= 1'b1;
                    if (w_timer_done) begin
                        r_timer <= TIMER_TOP;
                        if (r_byte_idx == LAST_BYTE) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_byte_idx <= r_byte_idx + 4'd1;
                            r_state    <= ST_START;
                        end
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
            endcase
        end
    end

    assign tx      = r_tx;
    assign busy    = r_busy;
    assign ovf_cnt = r_ovf;

endmodule

// File: tb/tb_sr_trace_tx.sv
// Self-checking bench for sr_trace_tx: record-level reference model compared every cycle, plus a UART receiver.
module tb_sr_trace_tx;

    localparam int DEPTH   = 4;
    localparam int CLK_DIV = 4;
`ifdef SR_TRACE_SYNC_EN
    localparam int NB = 13;
`else
    localparam int NB = 12;
`endif
    localparam int FC = 10 * NB * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        trace_valid;
    logic [31:0] trace_pc, trace_instr, trace_reg;
    logic        tx, busy;
    logic [7:0]  ovf_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    sr_trace_tx #(.DEPTH(DEPTH), .CLK_DIV(CLK_DIV)) dut (
        .clk         (clk),
        .rst         (rst),
        .trace_valid (trace_valid),
        .trace_pc    (trace_pc),
        .trace_instr (trace_instr),
        .trace_reg   (trace_reg),
        .tx          (tx),
        .busy        (busy),
        .ovf_cnt     (ovf_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [95:0] rec, input int b);
        logic [95:0] s;
`ifdef SR_TRACE_SYNC_EN
        if (b == 0) return 8'hA5;
        b = b - 1;
`endif
        s = rec >> (8 * b);
        return s[7:0];
    endfunction

    // Reference model: a queue of records and a transmitter that is either idle or some clocks into a frame.
    logic [95:0] mq[$];
    logic        fb [10*NB];
    int          elapsed = 0;
    bit          active  = 0;
    logic        m_tx    = 1'b1;
    logic        m_busy  = 1'b0;
    logic [7:0]  m_ovf   = 8'd0;

    function automatic void load_frame(input logic [95:0] rec);
        logic [7:0] b;
        for (int k = 0; k < NB; k++) begin
            b = exp_byte(rec, k);
            fb[10*k] = 1'b0;
            for (int i = 0; i < 8; i++) fb[10*k+1+i] = b[i];
            fb[10*k+9] = 1'b1;
        end
    endfunction

    always @(posedge clk) begin : model
        bit was_active;
        cyc++;
        if (rst) begin
            mq.delete();
            active  = 0;
            elapsed = 0;
            m_ovf   = 8'd0;
            m_tx    = 1'b1;
        end else begin
            was_active = active;
            if (was_active) begin
                elapsed++;
                m_tx = fb[(elapsed-1)/CLK_DIV];
                if (elapsed == FC) active = 0;
            end else begin
                m_tx = 1'b1;
            end
            if (!was_active && mq.size() > 0) begin
                load_frame(mq.pop_front());
                active  = 1;
                elapsed = 0;
            end
            if (trace_valid) begin
                if (mq.size() < DEPTH) mq.push_back({trace_reg, trace_instr, trace_pc});
                else if (m_ovf != 8'hFF) m_ovf++;
            end
        end
        m_busy = (mq.size() > 0) || active;
        #1;
        check("tx", {95'd0, tx}, {95'd0, m_tx});
        check("busy", {95'd0, busy}, {95'd0, m_busy});
        check("ovf_cnt", {88'd0, ovf_cnt}, {88'd0, m_ovf});
    end

    logic [7:0] rx_q[$];

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #2;
        end
    endtask

    // UART receiver sampling mid-bit on negedges; a missing start bit is logged and ends the task.
    task automatic rx_bytes(input int n);
        int         w;
        logic [7:0] b;
        rx_q.delete();
        for (int j = 0; j < n; j++) begin
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (tx !== 1'b0 && w < 4000);
            if (tx !== 1'b0) begin
                check("rx_start_timeout", {95'd0, tx}, 96'd0);
                return;
            end
            @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CLK_DIV) @(negedge clk);
                b[i] = tx;
            end
            repeat (CLK_DIV) @(negedge clk);
            check("rx_stop_bit", {95'd0, tx}, 96'd1);
            rx_q.push_back(b);
        end
    endtask

    task automatic push_one(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] rg,
                            output int n);
        @(negedge clk);
        trace_valid = 1'b1;
        trace_pc    = pc;
        trace_instr = ins;
        trace_reg   = rg;
        @(posedge clk);
        #2;
        n = cyc;
        @(negedge clk);
        trace_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int w = 0;
        while (busy !== 1'b0 && w < bound) begin
            @(negedge clk);
            w++;
        end
        check("drain_busy", {95'd0, busy}, 96'd0);
    endtask

    task automatic check_rx_record(input string name, input logic [95:0] rec, input int base);
        for (int i = 0; i < NB; i++)
            check(name, {88'd0, rx_q[base+i]}, {88'd0, exp_byte(rec, i)});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0]  exp1 [12];
        logic [95:0] recs[$];
        logic [95:0] rec;
        int          n;
        int          k;

        exp1 = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
        rst = 1'b1;
        trace_valid = 1'b0;
        trace_pc = '0;
        trace_instr = '0;
        trace_reg = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle after reset: line high, not busy, no drops.
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_tx", {95'd0, tx}, 96'd1);
            check("idle_busy", {95'd0, busy}, 96'd0);
            check("idle_ovf", {88'd0, ovf_cnt}, 96'd0);
        end

        // Single known record: latency and decoded byte stream.
        push_one(32'h0000_0004, 32'h0050_0513, 32'h0000_0005, n);
        wait_until(n + 1);
        check("lat_tx_n1", {95'd0, tx}, 96'd1);
        wait_until(n + 2);
        check("lat_tx_n2", {95'd0, tx}, 96'd0);
        rx_bytes(NB);
        check("rx_count1", rx_q.size(), NB);
        if (rx_q.size() == NB) begin
`ifdef SR_TRACE_SYNC_EN
            check("rx_sync", {88'd0, rx_q[0]}, 96'hA5);
`endif
            for (int i = 0; i < 12; i++)
                check("rx_literal", {88'd0, rx_q[NB-12+i]}, {88'd0, exp1[i]});
        end
        wait_until(n + FC);
        check("busy_last_clk", {95'd0, busy}, 96'd1);
        wait_until(n + FC + 1);
        check("busy_done", {95'd0, busy}, 96'd0);

        // Six back-to-back valids: one in flight, four buffered, one dropped.
        recs.delete();
        fork
            rx_bytes(5 * NB);
            begin
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    trace_valid = 1'b1;
                    trace_pc    = $urandom();
                    trace_instr = $urandom();
                    trace_reg   = $urandom();
                    recs.push_back({trace_reg, trace_instr, trace_pc});
                end
                @(negedge clk);
                trace_valid = 1'b0;
                check("burst_ovf", {88'd0, ovf_cnt}, 96'd1);
            end
        join
        check("rx_count5", rx_q.size(), 5 * NB);
        if (rx_q.size() == 5 * NB)
            for (int r = 0; r < 5; r++) check_rx_record("rx_burst", recs[r], r * NB);
        wait_idle(2 * FC);

        // Long stall of valids: drop counter saturates.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            trace_valid = 1'b1;
            trace_pc    = $urandom();
            trace_instr = $urandom();
            trace_reg   = $urandom();
        end
        @(negedge clk);
        trace_valid = 1'b0;
        check("ovf_saturated", {88'd0, ovf_cnt}, 96'd255);
        wait_idle((DEPTH + 2) * (FC + 2));

        // Reset in the middle of bit 3 of byte 5, then a clean record.
        push_one(32'h0000_0004, 32'h0050_0513, 32'h0000_0005, n);
        k = 5 * 10 * CLK_DIV + 4 * CLK_DIV;
        wait_until(n + 2 + k);
        check("tx_before_rst", {95'd0, tx}, 96'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;
        check("rst_tx", {95'd0, tx}, 96'd1);
        check("rst_busy", {95'd0, busy}, 96'd0);
        check("rst_ovf", {88'd0, ovf_cnt}, 96'd0);
        @(negedge clk);
        rst = 1'b0;
        rec = {32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_0100};
        push_one(rec[31:0], rec[63:32], rec[95:64], n);
        rx_bytes(NB);
        check("rx_count_after_rst", rx_q.size(), NB);
        if (rx_q.size() == NB) check_rx_record("rx_after_rst", rec, 0);
        wait_idle(2 * FC);

        // Randomized traffic: sparse and bursty phases, checked by the per-cycle model.
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            trace_valid = ($urandom_range(0, 99) < (((i / 500) % 2 == 1) ? 30 : 1));
            trace_pc    = $urandom();
            trace_instr = $urandom();
            trace_reg   = $urandom();
        end
        @(negedge clk);
        trace_valid = 1'b0;
        wait_idle((DEPTH + 2) * (FC + 2));

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
